// File: rtl/tt_um_jimktrains_vslc_timer_seq.sv
// Step sequencer for a VSLC timer: plays a table of (period_a, period_b, repeat) steps.
// Optional step_pulse output is built when VSLC_TIMER_SEQ_STEP_PULSE_EN is defined.
module tt_um_jimktrains_vslc_timer_seq #(
   parameter  int STEPS = 4,
   parameter  int PW    = 10,
   parameter  int RW    = 8,
   localparam int AW    = $clog2(STEPS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cfg_we,
   input  logic [AW-1:0] cfg_addr,
   input  logic [PW-1:0] cfg_period_a,
   input  logic [PW-1:0] cfg_period_b,
   input  logic [RW-1:0] cfg_repeat,
   input  logic          cfg_last,
   input  logic          start,
   input  logic          stop,
   input  logic          loop_en,
   input  logic          timer_output,
   output logic [PW-1:0] timer_period_a,
   output logic [PW-1:0] timer_period_b,
   output logic          timer_enabled,
   output logic [AW-1:0] step_idx,
   output logic          busy,
   output logic          done
`ifdef VSLC_TIMER_SEQ_STEP_PULSE_EN
   ,
   output logic          step_pulse
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] step_idx_q, step_idx_d;
   logic [RW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] per_a_q, per_a_d, per_b_q, per_b_d;
   logic          enabled_q, enabled_d;
   logic          done_q, done_d;
   logic          pulse_q, pulse_d;
   logic          prev_q;

   logic [PW-1:0] tbl_a_q    [STEPS];
   logic [PW-1:0] tbl_a_d    [STEPS];
   logic [PW-1:0] tbl_b_q    [STEPS];
   logic [PW-1:0] tbl_b_d    [STEPS];
   logic [RW-1:0] tbl_rep_q  [STEPS];
   logic [RW-1:0] tbl_rep_d  [STEPS];
   logic          tbl_last_q [STEPS];
   logic          tbl_last_d [STEPS];

   logic          edge_w;
   logic [RW-1:0] rep_eff;
   logic          step_end;
   logic          at_end;

   assign edge_w   = timer_output & ~prev_q;
   assign rep_eff  = (tbl_rep_q[step_idx_q] == '0) ? RW'(1) : tbl_rep_q[step_idx_q];
   assign step_end = (state_q == S_RUN) && edge_w &&
                     (({1'b0, cnt_q} + (RW+1)'(1)) >= {1'b0, rep_eff});
   assign at_end   = tbl_last_q[step_idx_q] || (step_idx_q == AW'(STEPS - 1));

   always_comb begin
      for (int i = 0; i < STEPS; i++) begin
         tbl_a_d[i]    = tbl_a_q[i];
         tbl_b_d[i]    = tbl_b_q[i];
         tbl_rep_d[i]  = tbl_rep_q[i];
         tbl_last_d[i] = tbl_last_q[i];
      end
      if (cfg_we) begin
         tbl_a_d[cfg_addr]    = cfg_period_a;
         tbl_b_d[cfg_addr]    = cfg_period_b;
         tbl_rep_d[cfg_addr]  = cfg_repeat;
         tbl_last_d[cfg_addr] = cfg_last;
      end
   end

   // State register and all other flops
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         step_idx_q <= '0;
         cnt_q      <= '0;
         per_a_q    <= '0;
         per_b_q    <= '0;
         enabled_q  <= 1'b0;
         done_q     <= 1'b0;
         pulse_q    <= 1'b0;
         prev_q     <= 1'b0;
         for (int i = 0; i < STEPS; i++) begin
            tbl_a_q[i]    <= '0;
            tbl_b_q[i]    <= '0;
            tbl_rep_q[i]  <= '0;
            tbl_last_q[i] <= 1'b0;
         end
      end else begin
         state_q    <= state_d;
         step_idx_q <= step_idx_d;
         cnt_q      <= cnt_d;
         per_a_q    <= per_a_d;
         per_b_q    <= per_b_d;
         enabled_q  <= enabled_d;
         done_q     <= done_d;
         pulse_q    <= pulse_d;
         prev_q     <= timer_output;
         for (int i = 0; i < STEPS; i++) begin
            tbl_a_q[i]    <= tbl_a_d[i];
            tbl_b_q[i]    <= tbl_b_d[i];
            tbl_rep_q[i]  <= tbl_rep_d[i];
            tbl_last_q[i] <= tbl_last_d[i];
         end
      end
   end

   // Next state: stop beats step-end, and start is only honoured from IDLE
   always_comb begin
      state_d    = state_q;
      step_idx_d = step_idx_q;
      if (stop) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: if (start) begin
               state_d    = S_LOAD;
               step_idx_d = '0;
            end
            S_LOAD: state_d = S_RUN;
            S_RUN: if (step_end) begin
               if (!at_end) begin
                  state_d    = S_LOAD;
                  step_idx_d = step_idx_q + AW'(1);
               end else if (loop_en) begin
                  state_d    = S_LOAD;
                  step_idx_d = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Registered outputs; periods are snapshotted on the way into LOAD
   always_comb begin
      per_a_d   = per_a_q;
      per_b_d   = per_b_q;
      cnt_d     = cnt_q;
      enabled_d = (state_d == S_RUN);
      done_d    = (state_q == S_RUN) && (state_d == S_IDLE) && !stop;
      pulse_d   = (state_q == S_RUN) && (state_d == S_LOAD);
      if (state_d == S_LOAD) begin
         per_a_d = tbl_a_q[step_idx_d];
         per_b_d = tbl_b_q[step_idx_d];
         cnt_d   = '0;
      end else if ((state_q == S_RUN) && edge_w && (cnt_q != '1)) begin
         cnt_d = cnt_q + RW'(1);
      end
   end

   assign timer_period_a = per_a_q;
   assign timer_period_b = per_b_q;
   assign timer_enabled  = enabled_q;
   assign step_idx       = step_idx_q;
   assign busy           = (state_q != S_IDLE);
   assign done           = done_q;
`ifdef VSLC_TIMER_SEQ_STEP_PULSE_EN
   assign step_pulse     = pulse_q;
`else
   logic unused_pulse;
   assign unused_pulse   = pulse_q;
`endif

endmodule
